// File: rtl/id_ctl_stage.sv
// id_ctl_stage: registered RV32I decode/control stage between IF/ID and EX with
// valid/ready handshakes, load-use stall, flush, illegal flagging and a saturating
// stall counter. Define ID_CTL_RV32M_EN to decode the RV32M multiply/divide group.
module id_ctl_stage #(
  parameter int PC_W      = 32,
  parameter int ALU_SEL_W = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_W-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic                 out_a_sel,
  output logic                 out_b_sel,
  output logic [ALU_SEL_W-1:0] out_alu_sel,
  output logic [2:0]           out_imm_sel,
  output logic [1:0]           out_wb_sel,
  output logic                 out_reg_wen,
  output logic                 out_mem_rd,
  output logic                 out_mem_wr,
  output logic [2:0]           out_mem_size,
  output logic                 out_is_branch,
  output logic                 out_is_jump,
  output logic [2:0]           out_br_op,
  output logic                 out_br_un,
  output logic                 out_illegal,
  output logic [CNT_W-1:0]     stall_cnt
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic                 a_sel;
    logic                 b_sel;
    logic [ALU_SEL_W-1:0] alu;
    logic [2:0]           imm_sel;
    logic [1:0]           wb_sel;
    logic                 reg_wen;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [2:0]           mem_size;
    logic                 is_branch;
    logic                 is_jump;
    logic [2:0]           br_op;
    logic                 br_un;
    logic                 illegal;
  } ctl_t;

  ctl_t             ctl_d, ctl_q;
  logic             valid_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rs1_used, rs2_used, hazard, accept;
  logic [6:0]       opc, f7;
  logic [2:0]       f3;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  // funct3 -> ALU code; alt selects SUB/SRA in the 000/101 slots
  function automatic logic [ALU_SEL_W-1:0] alu_of(input logic [2:0] fn, input logic alt);
    logic [4:0] c;
    case (fn)
      3'd0:    c = alt ? 5'd1 : 5'd0;
      3'd1:    c = 5'd2;
      3'd2:    c = 5'd3;
      3'd3:    c = 5'd4;
      3'd4:    c = 5'd5;
      3'd5:    c = alt ? 5'd7 : 5'd6;
      3'd6:    c = 5'd8;
      default: c = 5'd9;
    endcase
    return ALU_SEL_W'(c);
  endfunction

  // combinational decode of the presented instruction into a control bundle
  always_comb begin
    ctl_d     = '0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    ctl_d.rs1 = in_instr[19:15];
    ctl_d.rs2 = in_instr[24:20];
    ctl_d.rd  = in_instr[11:7];
    case (opc)
      OP_LUI: begin
        ctl_d.b_sel   = 1'b1;
        ctl_d.alu     = ALU_SEL_W'(5'd10);
        ctl_d.imm_sel = 3'd4;
        ctl_d.reg_wen = 1'b1;
      end
      OP_AUIPC: begin
        ctl_d.a_sel   = 1'b1;
        ctl_d.b_sel   = 1'b1;
        ctl_d.imm_sel = 3'd4;
        ctl_d.reg_wen = 1'b1;
      end
      OP_JAL: begin
        ctl_d.a_sel   = 1'b1;
        ctl_d.b_sel   = 1'b1;
        ctl_d.imm_sel = 3'd5;
        ctl_d.wb_sel  = 2'd2;
        ctl_d.reg_wen = 1'b1;
        ctl_d.is_jump = 1'b1;
      end
      OP_JALR: begin
        rs1_used      = 1'b1;
        ctl_d.b_sel   = 1'b1;
        ctl_d.imm_sel = 3'd1;
        ctl_d.wb_sel  = 2'd2;
        ctl_d.reg_wen = 1'b1;
        ctl_d.is_jump = 1'b1;
        ctl_d.illegal = f3 != 3'd0;
      end
      OP_BRANCH: begin
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
        ctl_d.a_sel     = 1'b1;
        ctl_d.b_sel     = 1'b1;
        ctl_d.imm_sel   = 3'd3;
        ctl_d.is_branch = 1'b1;
        ctl_d.br_op     = f3;
        ctl_d.br_un     = f3[1];
        ctl_d.illegal   = f3 == 3'd2 || f3 == 3'd3;
      end
      OP_LOAD: begin
        rs1_used       = 1'b1;
        ctl_d.b_sel    = 1'b1;
        ctl_d.imm_sel  = 3'd1;
        ctl_d.wb_sel   = 2'd1;
        ctl_d.reg_wen  = 1'b1;
        ctl_d.mem_rd   = 1'b1;
        ctl_d.mem_size = f3;
        ctl_d.illegal  = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
      end
      OP_STORE: begin
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        ctl_d.b_sel    = 1'b1;
        ctl_d.imm_sel  = 3'd2;
        ctl_d.mem_wr   = 1'b1;
        ctl_d.mem_size = f3;
        ctl_d.illegal  = f3 > 3'd2;
      end
      OP_OPIMM: begin
        rs1_used      = 1'b1;
        ctl_d.b_sel   = 1'b1;
        ctl_d.imm_sel = 3'd1;
        ctl_d.reg_wen = 1'b1;
        ctl_d.alu     = alu_of(f3, f3 == 3'd5 && f7 == F7_ALT);
        ctl_d.illegal = (f3 == 3'd1 && f7 != 7'd0) ||
                        (f3 == 3'd5 && f7 != 7'd0 && f7 != F7_ALT);
      end
      OP_OP: begin
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        ctl_d.reg_wen = 1'b1;
        if (f7 == 7'd0) ctl_d.alu = alu_of(f3, 1'b0);
        else if (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)) ctl_d.alu = alu_of(f3, 1'b1);
`ifdef ID_CTL_RV32M_EN
        else if (f7 == 7'b0000001) ctl_d.alu = ALU_SEL_W'({2'b10, f3});
`endif
        else ctl_d.illegal = 1'b1;
      end
      OP_MISC: ctl_d.illegal = 1'b0;
      default: ctl_d.illegal = 1'b1;
    endcase
    ctl_d.reg_wen   = ctl_d.reg_wen & ~ctl_d.illegal & (ctl_d.rd != 5'd0);
    ctl_d.mem_rd    = ctl_d.mem_rd & ~ctl_d.illegal;
    ctl_d.mem_wr    = ctl_d.mem_wr & ~ctl_d.illegal;
    ctl_d.is_branch = ctl_d.is_branch & ~ctl_d.illegal;
    ctl_d.is_jump   = ctl_d.is_jump & ~ctl_d.illegal;
  end

  assign hazard   = in_valid & valid_q & ctl_q.mem_rd & (ctl_q.rd != 5'd0) &
                    ((rs1_used & (ctl_d.rs1 == ctl_q.rd)) | (rs2_used & (ctl_d.rs2 == ctl_q.rd)));
  assign in_ready = (~valid_q | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  // ID/EX register: flush kills, accept loads, drained slot bubbles, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= (hazard && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
      if (flush) valid_q <= 1'b0;
      else if (accept) begin
        valid_q <= 1'b1;
        ctl_q   <= ctl_d;
        pc_q    <= in_pc;
      end else if (out_ready) valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_rs1       = ctl_q.rs1;
  assign out_rs2       = ctl_q.rs2;
  assign out_rd        = ctl_q.rd;
  assign out_a_sel     = ctl_q.a_sel;
  assign out_b_sel     = ctl_q.b_sel;
  assign out_alu_sel   = ctl_q.alu;
  assign out_imm_sel   = ctl_q.imm_sel;
  assign out_wb_sel    = ctl_q.wb_sel;
  assign out_reg_wen   = ctl_q.reg_wen;
  assign out_mem_rd    = ctl_q.mem_rd;
  assign out_mem_wr    = ctl_q.mem_wr;
  assign out_mem_size  = ctl_q.mem_size;
  assign out_is_branch = ctl_q.is_branch;
  assign out_is_jump   = ctl_q.is_jump;
  assign out_br_op     = ctl_q.br_op;
  assign out_br_un     = ctl_q.br_un;
  assign out_illegal   = ctl_q.illegal;
  assign stall_cnt     = cnt_q;
endmodule

// File: tb/tb_id_ctl_stage.sv
// tb_id_ctl_stage: directed self-checking bench for id_ctl_stage
module tb_id_ctl_stage;
  localparam int PC_W = 32;
  localparam int ALU_SEL_W = 5;
  localparam int CNT_W = 16;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic in_ready, out_valid, out_a_sel, out_b_sel, out_reg_wen, out_mem_rd, out_mem_wr;
  logic out_is_branch, out_is_jump, out_br_un, out_illegal;
  logic [PC_W-1:0] out_pc;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [ALU_SEL_W-1:0] out_alu_sel;
  logic [2:0] out_imm_sel, out_mem_size, out_br_op;
  logic [1:0] out_wb_sel;
  logic [CNT_W-1:0] stall_cnt;
  int total = 0, bad = 0;

  id_ctl_stage #(.PC_W(PC_W), .ALU_SEL_W(ALU_SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
    .out_alu_sel(out_alu_sel), .out_imm_sel(out_imm_sel), .out_wb_sel(out_wb_sel),
    .out_reg_wen(out_reg_wen), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_mem_size(out_mem_size), .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
    .out_br_op(out_br_op), .out_br_un(out_br_un), .out_illegal(out_illegal),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    in_instr = 32'h002081B3;
    in_pc = 32'h10;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", out_valid); end
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, out_pc, out_rs1, out_rs2, out_rd, out_a_sel, out_b_sel, out_alu_sel,
         out_imm_sel, out_wb_sel, out_reg_wen, out_mem_rd, out_mem_wr, out_mem_size,
         out_is_branch, out_is_jump, out_br_op, out_br_un, out_illegal, stall_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b pc=%h rd=%0d wen=%b cnt=%0d want all zero",
               out_valid, out_pc, out_rd, out_reg_wen, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_add_sub;
    in_instr = 32'h002081B3;
    in_pc = 32'h100;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, out_alu_sel, out_a_sel, out_b_sel, out_reg_wen, out_rd, out_rs1, out_rs2, out_pc}
        !== {1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h100}) begin
      bad++;
      $display("FAIL add_decode got v=%b alu=%0d a=%b b=%b wen=%b rd=%0d pc=%h want v=1 alu=0 a=0 b=0 wen=1 rd=3 pc=100",
               out_valid, out_alu_sel, out_a_sel, out_b_sel, out_reg_wen, out_rd, out_pc);
    end
    in_instr = 32'h402081B3;
    in_pc = 32'h104;
    @(negedge clk);
    total++;
    if ({out_valid, out_alu_sel, out_pc} !== {1'b1, 5'd1, 32'h104}) begin
      bad++;
      $display("FAIL sub_decode got v=%b alu=%0d pc=%h want v=1 alu=1 pc=104", out_valid, out_alu_sel, out_pc);
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_load_use;
    in_instr = 32'h0000A283;
    in_pc = 32'h200;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, out_mem_rd, out_rd, out_wb_sel, out_reg_wen, out_mem_size}
        !== {1'b1, 1'b1, 5'd5, 2'd1, 1'b1, 3'd2}) begin
      bad++;
      $display("FAIL lw_decode got v=%b mrd=%b rd=%0d wb=%0d wen=%b sz=%0d want 1 1 5 1 1 2",
               out_valid, out_mem_rd, out_rd, out_wb_sel, out_reg_wen, out_mem_size);
    end
    in_instr = 32'h00228333;
    in_pc = 32'h204;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL hazard_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    total++;
    if ({out_valid, stall_cnt} !== {1'b0, 16'd1}) begin
      bad++;
      $display("FAIL load_use_bubble got v=%b cnt=%0d want v=0 cnt=1", out_valid, stall_cnt);
    end
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL after_bubble_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    total++;
    if ({out_valid, out_rd, out_rs1, out_pc, stall_cnt} !== {1'b1, 5'd6, 5'd5, 32'h204, 16'd1}) begin
      bad++;
      $display("FAIL load_use_accept got v=%b rd=%0d rs1=%0d pc=%h cnt=%0d want 1 6 5 204 1",
               out_valid, out_rd, out_rs1, out_pc, stall_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk);
    in_instr = 32'h0000A283;
    in_pc = 32'h300;
    in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    flush = 1'b1;
    in_instr = 32'h00228333;
    in_pc = 32'h304;
    @(negedge clk);
    total++;
    if ({out_valid, stall_cnt} !== {1'b0, 16'd2}) begin
      bad++;
      $display("FAIL flush_hazard_count got v=%b cnt=%0d want v=0 cnt=2", out_valid, stall_cnt);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hold_flush;
    in_instr = 32'h00208463;
    in_pc = 32'h400;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_instr = 32'h002081B3;
    in_pc = 32'h404;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_is_branch, out_imm_sel, out_br_un, out_br_op, out_a_sel, out_b_sel,
           out_reg_wen, out_rs1, out_rs2, out_pc, in_ready}
          !== {1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 32'h400, 1'b0}) begin
        bad++;
        $display("FAIL hold_beq[%0d] got v=%b br=%b imm=%0d un=%b wen=%b pc=%h rdy=%b want 1 1 3 0 0 400 0",
                 k, out_valid, out_is_branch, out_imm_sel, out_br_un, out_reg_wen, out_pc, in_ready);
      end
    end
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_accept got=%b want=0", out_valid); end
  endtask

  task automatic test_illegal;
    in_instr = 32'hFFFFFFFF;
    in_pc = 32'h500;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, out_illegal, out_reg_wen, out_mem_rd, out_mem_wr, out_is_branch, out_is_jump}
        !== 7'b1100000) begin
      bad++;
      $display("FAIL illegal_ffff got v=%b ill=%b wen=%b mrd=%b mwr=%b br=%b j=%b want 1 1 0 0 0 0 0",
               out_valid, out_illegal, out_reg_wen, out_mem_rd, out_mem_wr, out_is_branch, out_is_jump);
    end
    in_instr = 32'h02208333;
    @(negedge clk);
    total++;
`ifdef ID_CTL_RV32M_EN
    if ({out_valid, out_illegal, out_alu_sel, out_reg_wen, out_a_sel, out_b_sel, out_wb_sel}
        !== {1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL mul_decode got v=%b ill=%b alu=%0d wen=%b want v=1 ill=0 alu=16 wen=1",
               out_valid, out_illegal, out_alu_sel, out_reg_wen);
    end
`else
    if ({out_valid, out_illegal, out_reg_wen} !== 3'b110) begin
      bad++;
      $display("FAIL mul_illegal got v=%b ill=%b wen=%b want v=1 ill=1 wen=0",
               out_valid, out_illegal, out_reg_wen);
    end
`endif
    in_instr = 32'h00100013;
    @(negedge clk);
    total++;
    if ({out_valid, out_reg_wen, out_illegal, out_b_sel, out_imm_sel, out_alu_sel, out_rd}
        !== {1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 5'd0, 5'd0}) begin
      bad++;
      $display("FAIL addi_x0 got v=%b wen=%b ill=%b b=%b imm=%0d alu=%0d want 1 0 0 1 1 0",
               out_valid, out_reg_wen, out_illegal, out_b_sel, out_imm_sel, out_alu_sel);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // expected: {a_sel, b_sel, alu[4:0], imm_sel[2:0], wb_sel[1:0], reg_wen, illegal}
  task automatic test_back_to_back;
    logic [31:0] ins [12] = '{32'h000010B7, 32'h00001097, 32'h008000EF, 32'h0020A023,
                              32'h4010D093, 32'h0010B093, 32'h0020E1B3, 32'h4020D1B3,
                              32'h40109093, 32'h4020F1B3, 32'h000090E7, 32'h0000B283};
    logic [13:0] exp [12] = '{{1'b0, 1'b1, 5'd10, 3'd4, 2'd0, 1'b1, 1'b0},
                              {1'b1, 1'b1, 5'd0,  3'd4, 2'd0, 1'b1, 1'b0},
                              {1'b1, 1'b1, 5'd0,  3'd5, 2'd2, 1'b1, 1'b0},
                              {1'b0, 1'b1, 5'd0,  3'd2, 2'd0, 1'b0, 1'b0},
                              {1'b0, 1'b1, 5'd7,  3'd1, 2'd0, 1'b1, 1'b0},
                              {1'b0, 1'b1, 5'd4,  3'd1, 2'd0, 1'b1, 1'b0},
                              {1'b0, 1'b0, 5'd8,  3'd0, 2'd0, 1'b1, 1'b0},
                              {1'b0, 1'b0, 5'd7,  3'd0, 2'd0, 1'b1, 1'b0},
                              {12'd0, 1'b0, 1'b1}, {12'd0, 1'b0, 1'b1},
                              {12'd0, 1'b0, 1'b1}, {12'd0, 1'b0, 1'b1}};
    logic [13:0] got;
    logic [13:0] want;
    out_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        got = {out_a_sel, out_b_sel, out_alu_sel, out_imm_sel, out_wb_sel, out_reg_wen, out_illegal};
        want = exp[i-1];
        if (want[0]) begin
          got[13:2] = '0;
          want[13:2] = '0;
        end
        total++;
        if (!out_valid || got !== want) begin
          bad++;
          $display("FAIL decode_table[%0d] instr=%h got v=%b fields=%b want v=1 fields=%b",
                   i - 1, ins[i-1], out_valid, got, want);
        end
      end
      if (i < 12) begin
        in_instr = ins[i];
        in_pc = 32'h600 + 32'(i * 4);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_saturate;
    in_instr = 32'h0000A283;
    in_pc = 32'h700;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_instr = 32'h00228333;
    repeat ((1 << CNT_W) + 3) @(negedge clk);
    total++;
    if ({stall_cnt, out_valid, out_rd, out_pc} !== {16'hFFFF, 1'b1, 5'd5, 32'h700}) begin
      bad++;
      $display("FAIL stall_saturate got cnt=%h v=%b rd=%0d pc=%h want cnt=ffff v=1 rd=5 pc=700",
               stall_cnt, out_valid, out_rd, out_pc);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if ({stall_cnt, out_valid} !== {16'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_clears_cnt got cnt=%h v=%b want cnt=0 v=0", stall_cnt, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_load_use();
    test_hold_flush();
    test_illegal();
    test_back_to_back();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ctl_stage.md
Name: id_ctl_stage

Overview:
- Registered RV32I decode/control stage between IF/ID and EX.
- Decodes one 32-bit instruction per accepted transfer into a control bundle held in an ID/EX output register.
- Upstream and downstream use valid/ready handshakes.
- Adds load-use hazard stalling, flush, illegal-instruction flagging and a saturating stall counter.

Parameters:
- PC_W, 32: width of in_pc/out_pc.
- ALU_SEL_W, 5: width of out_alu_sel; must be >=5.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts in_instr/in_pc this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- flush  in  1  kill in-flight contents (branch/jump redirect)
- out_valid  out  1  control bundle valid
- out_ready  in  1  EX accepts bundle
- out_pc  out  PC_W  registered pc
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_a_sel  out  1  0=rs1, 1=pc
- out_b_sel  out  1  0=rs2, 1=imm
- out_alu_sel  out  ALU_SEL_W  ALU operation code
- out_imm_sel  out  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J
- out_wb_sel  out  2  0=ALU, 1=MEM, 2=PC+4
- out_reg_wen, out_mem_rd, out_mem_wr  out  1 each
- out_mem_size  out  3  funct3 of load/store
- out_is_branch, out_is_jump  out  1 each
- out_br_op  out  3  branch funct3
- out_br_un  out  1  unsigned compare (funct3[1])
- out_illegal  out  1  undecodable instruction
- stall_cnt  out  CNT_W  count of hazard-stall cycles

Behaviour:
- Reset: asynchronous on rst_n low. All outputs 0, including out_valid and stall_cnt. Reset mid-transfer discards the bundle.
- Accept: accept = in_valid & in_ready. On accept, the decoded bundle is registered and out_valid=1 next cycle. Latency is 1 cycle.
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
- Hold: while out_valid & ~out_ready & ~flush, all out_* stay stable.
- Bubble: if out_ready=1 and there is no accept, out_valid goes to 0 next cycle.
- Hazard: hazard = in_valid & out_valid & out_mem_rd & (out_rd!=0) & ((rs1_used & rs1==out_rd) | (rs2_used & rs2==out_rd)).
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - Net effect: exactly one bubble per load-use.
- Flush: takes priority over everything. Next cycle out_valid=0. The input in the flush cycle is not accepted.
- stall_cnt: +1 each cycle hazard=1, including when flush is also high. Saturates at all-ones. No wrap.
- ALU codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- Decode by opcode (fields a_sel/b_sel/alu/imm/wb):
  - LUI 0110111: 0/1/PASSB/U/0.
  - AUIPC 0010111: 1/1/ADD/U/0.
  - JAL 1101111: 1/1/ADD/J/2, is_jump.
  - JALR 1100111: 0/1/ADD/I/2, is_jump; funct3!=000 is illegal.
  - BRANCH 1100011: 1/1/ADD/B, reg_wen=0, is_branch, br_op=funct3. funct3 010/011 are illegal.
  - LOAD 0000011: 0/1/ADD/I/1, mem_rd. funct3 011/110/111 are illegal.
  - STORE 0100011: 0/1/ADD/S, mem_wr, reg_wen=0. funct3>010 is illegal.
  - OP-IMM 0010011: 0/1/alu from funct3, imm=I. Shifts need funct7 0000000, or 0100000 for SRAI only.
  - OP 0110011: 0/0/alu from funct3+funct7[5]. funct7 0100000 is valid only for ADD→SUB and SRL→SRA; any other funct7 is illegal.
  - MISC-MEM 0001111: NOP, all controls 0.
  - Any other opcode: illegal.
- Illegal instruction: out_illegal=1 with reg_wen, mem_rd, mem_wr, is_branch, is_jump forced to 0. out_valid still asserts.
- reg_wen = 1 for writing opcodes only when rd!=0.
- rs1/rs2/rd fields are passed raw from instr[19:15], [24:20], [11:7].

Optional Feature:
- Macro ID_CTL_RV32M_EN.
- Defined: OP with funct7=0000001 decodes to alu codes 16+funct3 (MUL=16 .. REMU=23), with a_sel=0, b_sel=0, wb=0.
- Undefined: funct7=0000001 is illegal.

Test Plan:
- Reset: rst_n low mid-transfer with out_valid=1 -> all outputs 0, stall_cnt=0. After release, in_ready=1 and out_valid stays 0 until the first accept.
- ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu=0, a_sel=0, b_sel=0, reg_wen=1, rd=3. SUB 0x402081B3 -> alu=1.
- LW x5,0(x1) (0x0000A283) accepted, then ADD x6,x5,x2 (0x00228333) presented -> in_ready=0 for 1 cycle, one bubble (out_valid=0), ADD accepted the following cycle, stall_cnt=1.
- out_ready=0 holding BEQ (0x00208463) -> outputs stable for 5 cycles with is_branch=1, imm_sel=3, br_un=0. Then flush=1 -> out_valid=0 next cycle and the input is not accepted.
- 0xFFFFFFFF, then 0x02208333 (MUL) -> out_illegal=1 with reg_wen=0 for the first; for MUL, with ID_CTL_RV32M_EN alu=16, without it illegal.
- ADDI x0,x0,1 (0x00100013) -> reg_wen=0, illegal=0. Force 2^CNT_W+3 hazard cycles -> stall_cnt holds at all-ones.
